// File: rtl/rnn_fixed_pkg.sv
// rnn_fixed_pkg: width derivation, round/saturate helper and FSM states for matvec_mac_stream
package rnn_fixed_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DRAIN, DONE} state_t;
  typedef struct packed {
    logic signed [63:0] val;
    logic ovf;
  } fin_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction
  function automatic int bitwidth(input int qn, input int qm);
    return qn + qm + 1;
  endfunction
  function automatic int accw(input int bw, input int ncol);
    return 2 * bw + clog2(ncol) + 1;
  endfunction
  // s already carries the bias aligned to QM fractional bits
  function automatic fin_t finalise(input logic signed [63:0] s, input int qm, input int bw,
                                    input logic round_en, input logic sat_en);
    logic signed [63:0] r, hi, lo;
    fin_t f;
    r = (round_en ? s + (64'sd1 <<< (qm - 1)) : s) >>> qm;
    hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (bw - 1));
    f.ovf = sat_en && (r > hi || r < lo);
    f.val = (sat_en && r > hi) ? hi : (sat_en && r < lo) ? lo : r;
    return f;
  endfunction
endpackage

// File: rtl/mac_lane.sv
// mac_lane: one signed multiplier feeding a G-deep accumulator bank
//  clk/rst: clock, sync active-high reset; clr: zero bank on run start
//  en/grp/w/x: operand valid, target row group, weight and input (registered here)
//  acc: flattened bank, group g at [g*ACCW +: ACCW]
module mac_lane
  import rnn_fixed_pkg::*;
#(
  parameter int BW = 18,
  parameter int ACCW = 39,
  parameter int G = 4,
  parameter int GW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [GW-1:0]     grp,
  input  logic [BW-1:0]     w,
  input  logic [BW-1:0]     x,
  output logic [G*ACCW-1:0] acc
);
  logic signed [BW-1:0] w_r, x_r;
  logic [GW-1:0] g_r;
  logic v_r;
  logic signed [ACCW-1:0] bank [G];
  logic signed [2*BW-1:0] prod;
  assign prod = w_r * x_r;
  always_ff @(posedge clk)
    if (rst || clr) begin
      v_r <= 1'b0;
      g_r <= '0;
      w_r <= '0;
      x_r <= '0;
      for (int g = 0; g < G; g++) bank[g] <= '0;
    end else begin
      v_r <= en;
      g_r <= grp;
      w_r <= w;
      x_r <= x;
      if (v_r) bank[g_r] <= bank[g_r] + ACCW'(prod);
    end
  for (genvar g = 0; g < G; g++) begin : g_out
    assign acc[g*ACCW +: ACCW] = bank[g];
  end
endmodule

// File: rtl/matvec_mac_stream.sv
// matvec_mac_stream: time-multiplexed y = sat(round(W*x + b)) engine with start/busy/done handshake
//  start/busy: launch (IDLE only) and run-in-progress; colAddress: RAM column address
//  weightRow/inputVector: RAM data one cycle after address; biasVector: latched on accept
//  dataReady/overflow/outputVector: one-cycle done pulse, any-row clamp flag, held result
module matvec_mac_stream
  import rnn_fixed_pkg::*;
#(
  parameter int NROW = 16,
  parameter int NCOL = 4,
  parameter int QN = 6,
  parameter int QM = 11,
  parameter int LANES = 4,
  parameter bit ROUND_EN = 1'b1,
  parameter bit SAT_EN = 1'b1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  output logic                              busy,
  output logic [clog2(NCOL)-1:0]            colAddress,
  input  logic [bitwidth(QN, QM)*NROW-1:0]  weightRow,
  input  logic [bitwidth(QN, QM)-1:0]       inputVector,
  input  logic [bitwidth(QN, QM)*NROW-1:0]  biasVector,
  output logic                              dataReady,
  output logic                              overflow,
  output logic [bitwidth(QN, QM)*NROW-1:0]  outputVector
);
  localparam int BW = bitwidth(QN, QM);
  localparam int G = NROW / LANES;
  localparam int ACCW = accw(BW, NCOL);
  localparam int CW = clog2(NCOL);
  localparam int GW = G > 1 ? clog2(G) : 1;
  state_t state;
  logic [1:0] dcnt;
  logic [GW-1:0] grp, g1;
  logic v1, clr, last_col, last_grp, fin_ovf;
  logic [BW*NROW-1:0] bias, fin_vec;
  logic [LANES-1:0][BW-1:0] lane_w;
  logic [LANES-1:0][G*ACCW-1:0] lane_acc;
  fin_t f;
  assign clr = state == IDLE && start;
  assign last_col = colAddress == CW'(NCOL - 1);
  assign last_grp = grp == GW'(G - 1);
  // Finalise runs in the DONE cycle; result and dataReady register on leaving DONE
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      dataReady <= 1'b0;
      overflow <= 1'b0;
      colAddress <= '0;
      grp <= '0;
      g1 <= '0;
      v1 <= 1'b0;
      dcnt <= '0;
      bias <= '0;
      outputVector <= '0;
    end else begin
      dataReady <= 1'b0;
      v1 <= state == CALC;
      g1 <= grp;
      case (state)
        IDLE: begin
          busy <= start;
          if (start) begin
            state <= CALC;
            bias <= biasVector;
            overflow <= 1'b0;
            colAddress <= '0;
            grp <= '0;
          end
        end
        CALC: begin
          colAddress <= last_col ? '0 : colAddress + 1'b1;
          if (last_col) grp <= last_grp ? '0 : grp + 1'b1;
          if (last_col && last_grp) begin
            state <= DRAIN;
            dcnt <= '0;
          end
        end
        DRAIN: begin
          dcnt <= dcnt + 1'b1;
          if (dcnt == 2'd2) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
          dataReady <= 1'b1;
          overflow <= fin_ovf;
          outputVector <= fin_vec;
        end
        default: state <= IDLE;
      endcase
    end
  // RAM data belongs to the issue one cycle earlier, so select rows with the delayed group
  always_comb begin
    lane_w = '0;
    for (int l = 0; l < LANES; l++)
      for (int g = 0; g < G; g++)
        if (g1 == GW'(g)) lane_w[l] = weightRow[(l*G+g)*BW +: BW];
  end
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mac_lane #(.BW(BW), .ACCW(ACCW), .G(G), .GW(GW)) u_lane (
      .clk  (clk),
      .rst  (reset),
      .clr  (clr),
      .en   (v1),
      .grp  (g1),
      .w    (lane_w[l]),
      .x    (inputVector),
      .acc  (lane_acc[l])
    );
  end
  always_comb begin
    fin_vec = '0;
    fin_ovf = 1'b0;
    f = '0;
    for (int l = 0; l < LANES; l++)
      for (int g = 0; g < G; g++) begin
        f = finalise(64'(signed'(lane_acc[l][g*ACCW +: ACCW]))
                     + (64'(signed'(bias[(l*G+g)*BW +: BW])) <<< QM),
                     QM, BW, ROUND_EN, SAT_EN);
        fin_vec[(l*G+g)*BW +: BW] = f.val[BW-1:0];
        fin_ovf = fin_ovf | f.ovf;
      end
  end
endmodule

// File: tb/tb_matvec_mac_stream.sv
// tb_matvec_mac_stream: directed checks of two matvec_mac_stream builds (round+sat, trunc+wrap)
module tb_matvec_mac_stream;
  localparam int BW = 18;
  localparam int NR = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [BW*NR-1:0] weightRow = '0;
  logic [BW*NR-1:0] biasVector = '0;
  logic [BW-1:0] inputVector = '0;
  logic busy_a, busy_b, rdy_a, rdy_b, ovf_a, ovf_b;
  logic [0:0] col_a, col_b;
  logic [BW*NR-1:0] out_a, out_b;
  logic [BW*NR-1:0] w_mem [2];
  logic [BW-1:0] x_mem [2];
  int vectors = 0;
  int miscompares = 0;
  int pulses, first_rdy, second_rdy;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    weightRow <= w_mem[col_a];
    inputVector <= x_mem[col_a];
  end
  matvec_mac_stream #(.NROW(4), .NCOL(2), .QN(6), .QM(11), .LANES(2), .ROUND_EN(1'b1), .SAT_EN(1'b1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .busy(busy_a), .colAddress(col_a),
    .weightRow(weightRow), .inputVector(inputVector), .biasVector(biasVector),
    .dataReady(rdy_a), .overflow(ovf_a), .outputVector(out_a)
  );
  matvec_mac_stream #(.NROW(4), .NCOL(2), .QN(6), .QM(11), .LANES(2), .ROUND_EN(1'b0), .SAT_EN(1'b0)) dut_b (
    .clk(clk), .reset(reset), .start(start), .busy(busy_b), .colAddress(col_b),
    .weightRow(weightRow), .inputVector(inputVector), .biasVector(biasVector),
    .dataReady(rdy_b), .overflow(ovf_b), .outputVector(out_b)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [BW*NR-1:0] rows4(input logic [BW-1:0] r0, r1, r2, r3);
    return {r3, r2, r1, r0};
  endfunction
  task automatic set_w(input logic [BW-1:0] v);
    w_mem[0] = {NR{v}};
    w_mem[1] = {NR{v}};
  endtask
  task automatic set_x(input logic [BW-1:0] x0, x1);
    x_mem[0] = x0;
    x_mem[1] = x1;
  endtask
  // one full run: accept, measure latency to dataReady, check both builds' rows and flags
  task automatic run(input string tag, input logic [BW*NR-1:0] ea, eb, input logic eoa);
    int lat;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    lat = 0;
    while (!rdy_a && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd8);
    chk({tag, "_rdy_b"}, 64'(rdy_b), 64'd1);
    chk({tag, "_busy_at_rdy"}, 64'(busy_a), 64'd1);
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("%s_a_row%0d", tag, i), 64'(out_a[i*BW +: BW]), 64'(ea[i*BW +: BW]));
      chk($sformatf("%s_b_row%0d", tag, i), 64'(out_b[i*BW +: BW]), 64'(eb[i*BW +: BW]));
    end
    chk({tag, "_ovf_a"}, 64'(ovf_a), 64'(eoa));
    chk({tag, "_ovf_b"}, 64'(ovf_b), 64'd0);
    @(negedge clk);
    chk({tag, "_rdy_pulse_end"}, 64'(rdy_a), 64'd0);
    chk({tag, "_busy_fall"}, 64'(busy_a), 64'd0);
  endtask
  initial begin
    set_w('0);
    set_x('0, '0);
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy_a), 64'd0);
    chk("reset_rdy", 64'(rdy_a), 64'd0);
    chk("reset_ovf", 64'(ovf_a), 64'd0);
    chk("reset_col", 64'(col_a), 64'd0);
    chk("reset_out_a", 64'(out_a), 64'd0);
    chk("reset_busy_b", 64'(busy_b), 64'd0);
    reset = 1'b0;
    set_w(18'd2048);
    set_x(18'd2048, 18'd4096);
    biasVector = '0;
    run("basic", {NR{18'd6144}}, {NR{18'd6144}}, 1'b0);
    biasVector = rows4(18'd1024, 18'h3FC00, 18'd0, 18'd2048);
    run("bias", rows4(18'd7168, 18'd5120, 18'd6144, 18'd8192),
        rows4(18'd7168, 18'd5120, 18'd6144, 18'd8192), 1'b0);
    biasVector = '0;
    run("bias_cleared", {NR{18'd6144}}, {NR{18'd6144}}, 1'b0);
    set_w(18'd1);
    set_x(18'd1024, 18'd0);
    run("round_pos", {NR{18'd1}}, {NR{18'd0}}, 1'b0);
    set_w(18'h3FFFF);
    run("round_neg", {NR{18'd0}}, {NR{18'h3FFFF}}, 1'b0);
    set_w(18'h1FFFF);
    set_x(18'h1FFFF, 18'h1FFFF);
    run("sat_pos", {NR{18'h1FFFF}}, {NR{18'h3FF00}}, 1'b1);
    set_w(18'h20000);
    run("sat_neg", {NR{18'h20000}}, {NR{18'h00080}}, 1'b1);
    set_w(18'd2048);
    set_x(18'd2048, 18'd4096);
    pulses = 0;
    first_rdy = -1;
    second_rdy = -1;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 30; k++) begin
      @(negedge clk);
      if (k < 4) chk($sformatf("hs_col%0d", k), 64'(col_a), 64'(k % 2));
      if (k == 4) chk("hs_col_wrap", 64'(col_b), 64'd0);
      if (k == 8) chk("hs_busy_held", 64'(busy_a), 64'd1);
      if (rdy_a) begin
        pulses++;
        if (first_rdy < 0) first_rdy = k;
        else if (second_rdy < 0) second_rdy = k;
      end
      if (k == 17) begin
        chk("hs_row0", 64'(out_a[0 +: BW]), 64'd6144);
        start = 1'b0;
      end
      if (k == 20) chk("hs_busy_idle", 64'(busy_a), 64'd0);
    end
    chk("hs_pulses", 64'(pulses), 64'd2);
    chk("hs_first_rdy", 64'(first_rdy), 64'd8);
    chk("hs_second_rdy", 64'(second_rdy), 64'd17);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_rdy", 64'(rdy_a), 64'd0);
    chk("rst_ovf", 64'(ovf_a), 64'd0);
    chk("rst_col", 64'(col_a), 64'd0);
    chk("rst_out_a", 64'(out_a), 64'd0);
    chk("rst_out_b", 64'(out_b), 64'd0);
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (rdy_a || rdy_b) pulses++;
    end
    chk("rst_no_rdy", 64'(pulses), 64'd0);
    run("after_reset", {NR{18'd6144}}, {NR{18'd6144}}, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
